// File: rtl/robot_motor_driver.sv
// ============================================================================
// robot_motor_driver
//
// Purpose:
//   Stage that follows the wall-follower decision logic. It takes the advance
//   (a) and rotate (r) commands and drives the two wheel H-bridges with a PWM
//   enable and a direction bit per wheel.
//     - Each motion (FWD or TURN) is held for at least MIN_HOLD cycles, so a
//       command that chatters does not make the wheels chatter.
//     - A DEAD interval of DEADTIME cycles with both wheels off separates two
//       motions, so the right wheel is never reversed while it is driven.
//     - The current FSM state is exported as 'mode' for debug.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-low reset
//   a      in   1  advance command
//   r      in   1  rotate command (has priority over a)
//   pwm_l  out  1  left wheel PWM enable (registered)
//   pwm_r  out  1  right wheel PWM enable (registered)
//   dir_l  out  1  left wheel direction, 1 = forward (registered)
//   dir_r  out  1  right wheel direction, 1 = forward (registered)
//   mode   out  2  0 = STOP, 1 = FWD, 2 = TURN, 3 = DEAD (registered)
//
// Configuration macro:
//   MOTOR_RAMP_EN  when defined, the duty ramps up from 0 by RAMP_STEP at
//                  every PWM counter wrap after entering FWD/TURN (soft
//                  start). When undefined, the target duty applies at once.
// ============================================================================
module robot_motor_driver #(
    parameter int PWM_BITS  = 8,
    parameter int DUTY_FWD  = 192,
    parameter int DUTY_TURN = 128,
    parameter int DEADTIME  = 4,
    parameter int MIN_HOLD  = 16,
    parameter int RAMP_STEP = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       r,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        FWD  = 2'd1,
        TURN = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int DEAD_W = $clog2(DEADTIME + 1);

    localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [DEAD_W-1:0]   DEAD_MAX  = DEAD_W'(DEADTIME);
    localparam logic [PWM_BITS-1:0] DUTY_F    = PWM_BITS'(DUTY_FWD);
    localparam logic [PWM_BITS-1:0] DUTY_T    = PWM_BITS'(DUTY_TURN);

    // Illegal parameter sets are rejected at elaboration rather than
    // producing a driver whose duties or timers silently wrap.
    if (DEADTIME < 1 || MIN_HOLD < 1 ||
        DUTY_FWD  >= (1 << PWM_BITS) || DUTY_TURN >= (1 << PWM_BITS) ||
        RAMP_STEP >= (1 << PWM_BITS) || RAMP_STEP < 0) begin : g_badParams
        $error("robot_motor_driver: illegal parameter combination");
    end

    logic                r_aQ;
    logic                r_rQ;
    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [DEAD_W-1:0]   r_dead;
    logic [PWM_BITS-1:0] r_cnt;
    logic                r_pwmL;
    logic                r_pwmR;
    logic                r_dirL;
    logic                r_dirR;

    state_t              w_cmd;
    state_t              w_nextState;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] w_dutyNext;
    logic                w_dirR;

    // Inputs are registered once; the FSM only ever looks at the registered
    // copies, which gives one cycle of latency from a/r to a decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_aQ <= 1'b0;
            r_rQ <= 1'b0;
        end else begin
            r_aQ <= a;
            r_rQ <= r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= STOP;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Command decode and next-state logic. Rotation wins over advance so a
    // conflicting request never drives the robot forward into the wall.
    // The hold and dead counters read k at the k-th edge after entry, so a
    // comparison against MIN_HOLD / DEADTIME releases exactly on time.
    always_comb begin
        w_cmd       = STOP;
        w_nextState = r_state;
        if (r_rQ) begin
            w_cmd = TURN;
        end else if (r_aQ) begin
            w_cmd = FWD;
        end
        case (r_state)
            STOP: begin
                w_nextState = w_cmd;
            end
            FWD, TURN: begin
                if (r_hold >= HOLD_MAX && w_cmd != r_state) begin
                    w_nextState = DEAD;
                end
            end
            DEAD: begin
                if (r_dead >= DEAD_MAX) begin
                    w_nextState = w_cmd;
                end
            end
            default: begin
                w_nextState = STOP;
            end
        endcase
    end

    // Outputs are derived from the state being entered, so mode, direction
    // and PWM all change on the same edge (DEAD shows pwm=0 from its first
    // cycle on).
    always_comb begin
        w_target = '0;
        w_dirR   = 1'b1;
        case (w_nextState)
            FWD:     w_target = DUTY_F;
            TURN: begin
                w_target = DUTY_T;
                w_dirR   = 1'b0;
            end
            default: w_target = '0;
        endcase
    end

    // Time-in-state counters: restart at 1 on every state change and
    // saturate, so they stay narrow however long a state lasts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold <= '0;
            r_dead <= '0;
        end else if (w_nextState != r_state) begin
            r_hold <= HOLD_W'(1);
            r_dead <= DEAD_W'(1);
        end else begin
            if (r_hold < HOLD_MAX) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
            if (r_dead < DEAD_MAX) begin
                r_dead <= r_dead + DEAD_W'(1);
            end
        end
    end

    // Free-running PWM counter, wraps naturally at 2**PWM_BITS.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

`ifdef MOTOR_RAMP_EN
    localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS + 1)'(RAMP_STEP);

    logic [PWM_BITS-1:0] r_dutyCur;
    logic [PWM_BITS:0]   w_rampSum;

    // Soft start: duty restarts at 0 on entry to a motion and climbs by one
    // step per PWM period, clamped at the target. One extra bit on the sum
    // keeps the clamp correct when the step would overflow the counter width.
    always_comb begin
        w_rampSum  = {1'b0, r_dutyCur} + STEP_EXT;
        w_dutyNext = r_dutyCur;
        if (w_nextState == STOP || w_nextState == DEAD || w_nextState != r_state) begin
            w_dutyNext = '0;
        end else if (r_cnt == '1) begin
            if (w_rampSum >= {1'b0, w_target}) begin
                w_dutyNext = w_target;
            end else begin
                w_dutyNext = w_rampSum[PWM_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dutyCur <= '0;
        end else begin
            r_dutyCur <= w_dutyNext;
        end
    end
`else
    assign w_dutyNext = w_target;
`endif

    // Registered PWM and direction outputs; both wheels share one duty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pwmL <= 1'b0;
            r_pwmR <= 1'b0;
            r_dirL <= 1'b1;
            r_dirR <= 1'b1;
        end else begin
            r_pwmL <= (r_cnt < w_dutyNext);
            r_pwmR <= (r_cnt < w_dutyNext);
            r_dirL <= 1'b1;
            r_dirR <= w_dirR;
        end
    end

    assign pwm_l = r_pwmL;
    assign pwm_r = r_pwmR;
    assign dir_l = r_dirL;
    assign dir_r = r_dirR;
    assign mode  = r_state;

endmodule

// File: tb/tb_robot_motor_driver.sv
// ============================================================================
// tb_robot_motor_driver
//
// Purpose:
//   Self-checking bench for robot_motor_driver (default build, no ramp).
//   Directed scenarios followed by random a/r segments with occasional reset
//   pulses. The reference model tracks the motion mode, the edge at which it
//   was entered and the PWM phase as plain integers.
// ============================================================================
module tb_robot_motor_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       a;
    logic       r;
    logic       pwm_l;
    logic       pwm_r;
    logic       dir_l;
    logic       dir_r;
    logic [1:0] mode;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int mMode   = 0;
    int mEntry  = 0;
    int mEdge   = 0;
    int mPhase  = 0;
    int mAq     = 0;
    int mRq     = 0;
    int mPwm    = 0;
    int mDirR   = 1;

    robot_motor_driver dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .r     (r),
        .pwm_l (pwm_l),
        .pwm_r (pwm_r),
        .dir_l (dir_l),
        .dir_r (dir_r),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a miscompare with its tag.
    task automatic checkOne(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model for one rising edge, written from the behavioural
    // rules: command priority, minimum age in a motion, dead interval length
    // and PWM phase since reset.
    task automatic modelEdge(input int inReset, input int inA, input int inR);
        int cmd;
        int age;
        int newMode;
        int duty;
        int phaseBefore;
        if (inReset == 0) begin
            mMode  = 0;
            mEntry = 0;
            mEdge  = 0;
            mPhase = 0;
            mAq    = 0;
            mRq    = 0;
            mPwm   = 0;
            mDirR  = 1;
        end else begin
            cmd         = (mRq != 0) ? 2 : ((mAq != 0) ? 1 : 0);
            mEdge       = mEdge + 1;
            phaseBefore = mPhase;
            mPhase      = (mPhase + 1) % 256;
            age         = mEdge - mEntry;
            newMode     = mMode;
            if (mMode == 0) begin
                newMode = cmd;
            end else if (mMode == 1 || mMode == 2) begin
                if (age >= 16 && cmd != mMode) newMode = 3;
            end else begin
                if (age >= 4) newMode = cmd;
            end
            if (newMode != mMode) mEntry = mEdge;
            mMode = newMode;
            mAq   = inA;
            mRq   = inR;
            duty  = (mMode == 1) ? 192 : ((mMode == 2) ? 128 : 0);
            mPwm  = (phaseBefore < duty) ? 1 : 0;
            mDirR = (mMode == 2) ? 0 : 1;
        end
    endtask

    task automatic checkOutput();
        checkOne("mode",  int'(mode),  mMode);
        checkOne("pwm_l", int'(pwm_l), mPwm);
        checkOne("pwm_r", int'(pwm_r), mPwm);
        checkOne("dir_l", int'(dir_l), 1);
        checkOne("dir_r", int'(dir_r), mDirR);
    endtask

    // Drives one cycle of inputs (called just after a falling edge), lets
    // the DUT and the model take the rising edge, then samples on the next
    // falling edge.
    task automatic applyStimulus(input int inReset, input int inA, input int inR);
        reset = inReset[0];
        a     = inA[0];
        r     = inR[0];
        @(posedge clk);
        modelEdge(inReset, inA, inR);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int highs;
        reset = 1'b0;
        a     = 1'b0;
        r     = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a=1, then straight advance.
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        highs = 0;
        for (int i = 0; i < 280; i++) begin
            applyStimulus(1, 1, 0);
            if (i >= 20 && i < 276 && pwm_l === 1'b1) highs++;
        end
        checkOne("fwdHighsPer256", highs, 192);

        // Switch to rotate: hold, dead interval, then TURN at half duty.
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 0, 1);
            if (i >= 40 && i < 296 && pwm_r === 1'b1) highs++;
        end
        checkOne("turnHighsPer256", highs, 128);

        // Drop both commands: dead interval then STOP.
        for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0);

        // a=r=1 decodes as TURN; reset pulse in the middle of the turn.
        for (int i = 0; i < 15; i++) applyStimulus(1, 1, 1);
        applyStimulus(0, 1, 1);
        for (int i = 0; i < 25; i++) applyStimulus(1, 1, 1);

        // Random command segments with rare reset pulses.
        for (int s = 0; s < 80; s++) begin
            int ra;
            int rr;
            int len;
            ra  = int'($urandom_range(0, 1));
            rr  = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                applyStimulus(($urandom_range(0, 199) == 0) ? 0 : 1, ra, rr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
